// File: rtl/cache_ctrl.sv
// cache_ctrl
// Sequencing controller for a direct-mapped, write-back, write-allocate cache.
// Sits between a CPU word port and a block-wide memory port. Holds the
// valid/dirty/tag/data line array, decides hit or miss, writes back dirty
// victims, refills lines and keeps saturating hit/miss counters.
//
// Ports
//   clk, rst                 clock (posedge) and synchronous active-high reset
//   cpu_req/cpu_we           CPU access request and write flag, held until cpu_ready
//   cpu_addr/cpu_wdata       byte address (bits [1:0] ignored) and write word
//   cpu_rdata/cpu_ready      read word and one-cycle completion pulse
//   mem_req/mem_we           block request (held until mem_ack), 1 = write-back
//   mem_addr/mem_wdata       line-aligned address and victim line
//   mem_rdata/mem_ack        refill line and one-cycle memory completion
//   hit_cnt/miss_cnt         first-try hits and misses, saturating
//
// State      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for cpu_req; request fields latched on acceptance
// S_COMPARE  | tag lookup; hit completes the access, miss picks WB or REFILL
// S_WB       | dirty victim line being written to memory
// S_REFILL   | requested line being read from memory, then re-compare
module cache_ctrl #(
    parameter int CACHE_SIZE  = 12,
    parameter int BLOCK_SIZE  = 8,
    parameter int BLOCK_WIDTH = BLOCK_SIZE * 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic [31:0]            cpu_rdata,
    output logic                   cpu_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [BLOCK_WIDTH-1:0] mem_wdata,
    input  logic [BLOCK_WIDTH-1:0] mem_rdata,
    input  logic                   mem_ack,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
);

    localparam int BLOCK_POS = $clog2(BLOCK_SIZE);
    localparam int OFF_W     = BLOCK_POS + 2;
    localparam int IDX_W     = CACHE_SIZE - OFF_W;
    localparam int TAG_W     = 32 - CACHE_SIZE;
    localparam int LINES     = 1 << IDX_W;
    localparam int WORD_W    = (BLOCK_POS > 0) ? BLOCK_POS : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WB,
        S_REFILL
    } state_t;

    state_t state_q, state_d;

    // Line array: status bits are reset, tag/data are not.
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [BLOCK_WIDTH-1:0] data_mem [LINES];

    // Latched request; byte-lane bits are never stored.
    logic [31:2] req_addr_q;
    logic        req_we_q;
    logic [31:0] req_wdata_q;
    logic        refilled_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;

    logic                   line_valid;
    logic                   line_dirty;
    logic [TAG_W-1:0]       line_tag;
    logic [BLOCK_WIDTH-1:0] line_data;

    logic accept;
    logic lookup_hit;
    logic cmp_hit;
    logic cmp_miss;
    logic wr_hit;
    logic refill_done;

    logic [31:0]            cpu_rdata_d;
    logic                   cpu_ready_d;
    logic                   mem_req_d;
    logic                   mem_we_d;
    logic [31:0]            mem_addr_d;
    logic [BLOCK_WIDTH-1:0] mem_wdata_d;
    logic [31:0]            hit_cnt_d;
    logic [31:0]            miss_cnt_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_tag = req_addr_q[31:CACHE_SIZE];
    assign req_idx = req_addr_q[CACHE_SIZE-1:OFF_W];

    generate
        if (BLOCK_POS > 0) begin : g_word_sel
            assign req_word = req_addr_q[OFF_W-1:2];
        end else begin : g_single_word
            assign req_word = '0;
        end
    endgenerate

    assign line_valid = valid_q[req_idx];
    assign line_dirty = dirty_q[req_idx];
    assign line_tag   = tag_mem[req_idx];
    assign line_data  = data_mem[req_idx];

    assign accept      = (state_q == S_IDLE) && cpu_req;
    assign lookup_hit  = line_valid && (line_tag == req_tag);
    assign cmp_hit     = (state_q == S_COMPARE) && lookup_hit;
    assign cmp_miss    = (state_q == S_COMPARE) && !lookup_hit;
    assign wr_hit      = cmp_hit && req_we_q;
    assign refill_done = (state_q == S_REFILL) && mem_ack;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (lookup_hit) begin
                    state_d = S_IDLE;
                end else if (line_valid && line_dirty) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    state_d = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        cpu_ready_d = cmp_hit;
        cpu_rdata_d = cpu_rdata;
        mem_req_d   = (state_d == S_WB) || (state_d == S_REFILL);
        mem_we_d    = (state_d == S_WB);
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        hit_cnt_d   = hit_cnt;
        miss_cnt_d  = miss_cnt;

        if (cmp_hit && !req_we_q) begin
            cpu_rdata_d = line_data[{req_word, 5'd0} +: 32];
        end

        if (state_d == S_WB && state_q == S_COMPARE) begin
            mem_addr_d  = {line_tag, req_idx, {OFF_W{1'b0}}};
            mem_wdata_d = line_data;
        end else if (state_d == S_REFILL) begin
            mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
        end

        // The re-compare after a refill always hits but is not a first-try hit.
        if (cmp_hit && !refilled_q && (hit_cnt != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt + 32'd1;
        end
        if (cmp_miss && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt + 32'd1;
        end
    end

    // Registered outputs and line status
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            refilled_q <= 1'b0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            cpu_ready <= cpu_ready_d;
            cpu_rdata <= cpu_rdata_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            hit_cnt   <= hit_cnt_d;
            miss_cnt  <= miss_cnt_d;

            if (accept) begin
                refilled_q <= 1'b0;
            end
            if (wr_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (refill_done) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
                refilled_q       <= 1'b1;
            end
        end
    end

    // Request latch and tag/data storage, not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr_q  <= cpu_addr[31:2];
            req_we_q    <= cpu_we;
            req_wdata_q <= cpu_wdata;
        end
        if (!rst) begin
            if (wr_hit) begin
                data_mem[req_idx][{req_word, 5'd0} +: 32] <= req_wdata_q;
            end
            if (refill_done) begin
                data_mem[req_idx] <= mem_rdata;
                tag_mem[req_idx]  <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    localparam int LINES = 128;
    localparam int WORDS = 8;

    logic         clk;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_ack;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    cache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           we;
        logic [31:0]  addr;
        logic [255:0] data;
    } mem_exp_t;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
        logic [31:0] hits;
        logic [31:0] misses;
    } cpu_exp_t;

    mem_exp_t mem_q[$];
    cpu_exp_t cpu_q[$];

    int tests   = 0;
    int fails   = 0;
    int mem_lat = 3;

    // Reference model: what the cache should hold and what memory should hold.
    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES][WORDS];
    logic [31:0] m_hits;
    logic [31:0] m_misses;
    logic [31:0] ref_mem [int unsigned];

    // Bench memory actually serving the DUT.
    logic [31:0] bmem [int unsigned];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return ((a & 32'hFFFF_FFE0) - 32'h1000) + ((a >> 2) & 32'h7) * 32'h11;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_word(a);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = '0;
        m_misses = '0;
    endtask

    task automatic model_access(input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, output bit hit);
        int unsigned idx;
        int unsigned w;
        logic [31:0] tag;
        logic [31:0] line;
        logic [31:0] vaddr;
        mem_exp_t    me;
        cpu_exp_t    ce;
        idx  = (addr >> 5) % LINES;
        w    = (addr >> 2) % WORDS;
        tag  = addr >> 12;
        line = addr & 32'hFFFF_FFE0;
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) begin
            m_hits = sat_inc(m_hits);
        end else begin
            m_misses = sat_inc(m_misses);
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr   = (m_tag[idx] << 12) + (idx << 5);
                me.we   = 1'b1;
                me.addr = vaddr;
                me.data = '0;
                for (int k = 0; k < WORDS; k++) begin
                    me.data[32*k +: 32]  = m_data[idx][k];
                    ref_mem[(vaddr >> 2) + k] = m_data[idx][k];
                end
                mem_q.push_back(me);
            end
            me.we   = 1'b0;
            me.addr = line;
            me.data = '0;
            mem_q.push_back(me);
            for (int k = 0; k < WORDS; k++) begin
                m_data[idx][k] = ref_rd(line + 4 * k);
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
        end
        ce.we    = we;
        ce.rdata = m_data[idx][w];
        if (we) begin
            m_data[idx][w] = wdata;
            m_dirty[idx]   = 1'b1;
        end
        ce.hits   = m_hits;
        ce.misses = m_misses;
        cpu_q.push_back(ce);
    endtask

    // Issue one access starting at a negedge; returns at the negedge where
    // cpu_ready is seen. keep=1 leaves cpu_req high for an immediate follow-up.
    task automatic do_access(input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit keep);
        bit hit;
        int n;
        model_access(we, addr, wdata, hit);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 200);
        if (!cpu_ready) begin
            tests++;
            fails++;
            $display("FAIL cpu_timeout: no cpu_ready within %0d cycles for addr %0h", n, addr);
            finish_run();
        end
        if (hit) check("hit_latency", n, 2);
        if (!keep) cpu_req = 1'b0;
    endtask

    // Scoreboard monitor for CPU completions.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                if (cpu_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cpu_ready_unexpected: cpu_ready=1 with no access outstanding");
                end else begin
                    e = cpu_q.pop_front();
                    if (!e.we) check("cpu_rdata", cpu_rdata, e.rdata);
                    check("hit_cnt", hit_cnt, e.hits);
                    check("miss_cnt", miss_cnt, e.misses);
                end
            end
        end
    end

    // Memory responder; also checks each block request against the model.
    initial begin
        mem_exp_t    e;
        bit          t_we;
        logic [31:0] t_addr;
        int unsigned k;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        forever begin
            if (mem_req) begin
                t_we   = mem_we;
                t_addr = mem_addr;
                if (mem_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_req_unexpected: we=%0b addr=%0h", mem_we, mem_addr);
                end else begin
                    e = mem_q.pop_front();
                    check("mem_we", mem_we, e.we);
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) check("mem_wdata", mem_wdata, e.data);
                end
                for (int w = 0; w < WORDS; w++) begin
                    k = (t_addr >> 2) + w;
                    if (t_we) begin
                        bmem[k] = mem_wdata[32*w +: 32];
                    end
                end
                repeat (mem_lat - 1) @(negedge clk);
                for (int w = 0; w < WORDS; w++) begin
                    k = (t_addr >> 2) + w;
                    mem_rdata[32*w +: 32] = bmem.exists(k) ? bmem[k] : init_word(t_addr + 4 * w);
                end
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit_flag;
        int n;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Cold read miss, then a hit in the same line.
        do_access(1'b0, 32'h0000_1000, 32'h0, 1'b0);
        @(negedge clk);
        do_access(1'b0, 32'h0000_1004, 32'h0, 1'b0);

        // Dirty the line, then evict it with a conflicting tag.
        @(negedge clk);
        do_access(1'b1, 32'h0000_1008, 32'hDEAD_BEEF, 1'b1);
        do_access(1'b0, 32'h0000_2008, 32'h0, 1'b0);

        // Clean victim: refill only.
        @(negedge clk);
        do_access(1'b0, 32'h0000_3000, 32'h0, 1'b0);

        // Reset in the middle of a refill; the late ack must be ignored.
        @(negedge clk);
        model_access(1'b0, 32'h0000_4000, 32'h0, hit_flag);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_4000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 50);
        check("refill_started", mem_req, 1);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_drops_mem_req", mem_req, 0);
        cpu_q.delete();
        model_reset();
        repeat (6) begin
            @(negedge clk);
            check("late_ack_mem_req", mem_req, 0);
            check("late_ack_cpu_ready", cpu_ready, 0);
        end
        check("post_rst_hit_cnt", hit_cnt, 0);
        check("post_rst_miss_cnt", miss_cnt, 0);
        do_access(1'b0, 32'h0000_2000, 32'h0, 1'b0);

        // Hit counter saturation.
        @(negedge clk);
        force dut.hit_cnt = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_cnt;
        m_hits = 32'hFFFF_FFFE;
        check("forced_hit_cnt", hit_cnt, 32'hFFFF_FFFE);
        do_access(1'b0, 32'h0000_2004, 32'h0, 1'b1);
        do_access(1'b1, 32'h0000_2008, 32'h1234_5678, 1'b1);
        do_access(1'b0, 32'h0000_2008, 32'h0, 1'b0);

        // Randomized traffic over a few conflicting tags and indices.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            bit          we;
            a = ($urandom_range(0, 5) << 12) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
            we = ($urandom_range(0, 2) == 0);
            mem_lat = $urandom_range(1, 4);
            do_access(we, a, $urandom, 1'($urandom_range(0, 1)));
            if (!cpu_req) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        cpu_req = 1'b0;
        repeat (10) @(negedge clk);
        check("cpu_q_drained", cpu_q.size(), 0);
        check("mem_q_drained", mem_q.size(), 0);
        finish_run();
    end

endmodule
